// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared types and helpers for the data-memory load/store unit
package dmem_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   typedef struct packed {
      logic [1:0] off;
      logic [1:0] size;
      logic       uns;
      logic       we;
      logic       err;
   } meta_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         SZ_R:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - store lane/data generation and load extract/extend
// Purely combinational; offsets are normalised so unaligned halves/words fold down.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_we,
   output logic [31:0] st_din,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_uns,
   input  logic [31:0] ld_dout,
   output logic [31:0] ld_data
);

   logic [1:0]  ld_off_eff;
   logic [31:0] shifted;

   always_comb begin
      st_we  = 4'b1111;
      st_din = st_wdata;
      case (st_size)
         SZ_B: begin
            st_we  = 4'b0001 << st_off;
            st_din = {4{st_wdata[7:0]}};
         end
         SZ_H: begin
            st_we  = 4'b0011 << {st_off[1], 1'b0};
            st_din = {2{st_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_size)
         SZ_B:    ld_off_eff = ld_off;
         SZ_H:    ld_off_eff = {ld_off[1], 1'b0};
         default: ld_off_eff = 2'b00;
      endcase
      shifted = ld_dout >> {ld_off_eff, 3'b000};
      case (ld_size)
         SZ_B:    ld_data = ld_uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    ld_data = ld_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving a registered-read, byte-enabled data memory
// Optional MISALIGN_TRAP_EN: misaligned/reserved accesses skip memory and return rsp_err.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   state_e      state_q, state_d;
   meta_t       meta_q, meta_d;
   logic        hs;
   logic        req_err;
   logic        access;
   logic [3:0]  st_we;
   logic [31:0] st_din;
   logic [31:0] ld_data;

   dmem_lsu_align u_align (
      .st_size  (req_size),
      .st_off   (req_addr[1:0]),
      .st_wdata (req_wdata),
      .st_we    (st_we),
      .st_din   (st_din),
      .ld_size  (meta_q.size),
      .ld_off   (meta_q.off),
      .ld_uns   (meta_q.uns),
      .ld_dout  (mem_dout),
      .ld_data  (ld_data)
   );

   always_comb begin
`ifdef MISALIGN_TRAP_EN
      req_err = misaligned(req_size, req_addr[1:0]);
`else
      req_err = 1'b0;
`endif
      req_ready = (state_q == IDLE) || rsp_ready;
      // Gating with rst_n keeps a write from leaking out while reset is held.
      hs        = req_valid && req_ready && rst_n;
      access    = hs && !req_err;

      mem_en   = access;
      mem_addr = access ? req_addr[ADDR_W-1:2] : '0;
      mem_we   = (access && req_we) ? st_we  : 4'b0000;
      mem_din  = (access && req_we) ? st_din : 32'h0;

      meta_d = meta_q;
      if (hs) begin
         meta_d = '{off: req_addr[1:0], size: req_size, uns: req_unsigned,
                    we: req_we, err: req_err};
      end

      state_d = state_q;
      if (hs)             state_d = RESP;
      else if (rsp_ready) state_d = IDLE;

      // While stalled mem_en stays low, so mem_dout and hence rsp_rdata hold.
      rsp_valid = (state_q == RESP);
      rsp_err   = rsp_valid && meta_q.err;
      rsp_rdata = (rsp_valid && !meta_q.we && !meta_q.err) ? ld_data : 32'h0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         meta_q  <= '0;
      end else begin
         state_q <= state_d;
         meta_q  <= meta_d;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with byte-level reference model
module tb_dmem_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_din, mem_dout;

   int passed = 0;
   int total  = 0;

   logic [31:0] pmem [0:16383];
   logic [7:0]  bmem [0:65535];

   logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_en;
   logic [31:0] o_rsp_rdata, o_mem_din;
   logic [3:0]  o_mem_we;
   logic [13:0] o_mem_addr;

   dmem_lsu #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= pmem[mem_addr];
         for (int i = 0; i < 4; i++)
            if (mem_we[i]) pmem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      end
   end

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic ref_err(input logic [1:0] sz, input logic [15:0] a);
`ifdef MISALIGN_TRAP_EN
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
      return (sz == 2'd3) && (a == 16'hFFFF) && 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [15:0] a);
      int n = nbytes(sz);
      int base = int'(a) - (int'(a) % n);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(bmem[base + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic void ref_store(input logic [1:0] sz, input logic [15:0] a, input logic [31:0] wd);
      int n = nbytes(sz);
      int base = int'(a) - (int'(a) % n);
      for (int i = 0; i < n; i++) bmem[base + i] = 8'(wd >> (8 * i));
   endfunction

   function automatic logic [3:0] ref_lanes(input logic [1:0] sz, input logic [15:0] a);
      int n = nbytes(sz);
      int base = int'(a) - (int'(a) % n);
      return 4'(((1 << n) - 1) << (base % 4));
   endfunction

   function automatic logic [31:0] ref_din(input logic [1:0] sz, input logic [31:0] wd);
      int n = nbytes(sz);
      if (n == 1) return {4{wd[7:0]}};
      if (n == 2) return {2{wd[15:0]}};
      return wd;
   endfunction

   task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [31:0] wd, input logic rr);
      req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; rsp_ready = rr;
      #3;
      o_req_ready = req_ready; o_rsp_valid = rsp_valid; o_rsp_err = rsp_err;
      o_rsp_rdata = rsp_rdata; o_mem_en = mem_en; o_mem_we = mem_we;
      o_mem_addr = mem_addr; o_mem_din = mem_din;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
      total++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else passed++;
      total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else passed++;
      total++; if ({mem_en, mem_we, mem_addr, mem_din} !== '0)
         $display("FAIL reset_mem got en=%b we=%b addr=%h din=%h want all 0", mem_en, mem_we, mem_addr, mem_din);
      else passed++;
      rst_n = 1'b1;
      #3;
      total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      drive(1, 1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, 1); ref_store(2'd2, 16'h0010, 32'hDEADBEEF);
      total++; if (o_mem_we !== 4'b1111) $display("FAIL word_we got %b want 1111", o_mem_we); else passed++;
      total++; if (o_mem_addr !== 14'd4) $display("FAIL word_addr got %0d want 4", o_mem_addr); else passed++;
      total++; if (o_mem_din !== 32'hDEADBEEF) $display("FAIL word_din got %h want deadbeef", o_mem_din); else passed++;
      drive(1, 0, 2'd2, 0, 16'h0010, 32'h0, 1);
      total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0)
         $display("FAIL word_store_rsp got v=%b d=%h want v=1 d=0", o_rsp_valid, o_rsp_rdata); else passed++;
      total++; if (o_mem_en !== 1'b1 || o_mem_we !== 4'b0) $display("FAIL word_load_en got en=%b we=%b want 1/0", o_mem_en, o_mem_we); else passed++;
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
      total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hDEADBEEF)
         $display("FAIL word_load_rsp got v=%b d=%h want v=1 d=deadbeef", o_rsp_valid, o_rsp_rdata); else passed++;
      total++; if (o_mem_en !== 1'b0) $display("FAIL idle_mem_en got %b want 0", o_mem_en); else passed++;
   endtask

   task automatic test_byte();
      drive(1, 1, 2'd0, 0, 16'h0013, 32'h000000A5, 1); ref_store(2'd0, 16'h0013, 32'hA5);
      total++; if (o_mem_we !== 4'b1000) $display("FAIL byte_we got %b want 1000", o_mem_we); else passed++;
      total++; if (o_mem_din !== 32'hA5A5A5A5) $display("FAIL byte_din got %h want a5a5a5a5", o_mem_din); else passed++;
      drive(1, 0, 2'd0, 0, 16'h0013, 32'h0, 1);
      drive(1, 0, 2'd0, 1, 16'h0013, 32'h0, 1);
      total++; if (o_rsp_rdata !== 32'hFFFFFFA5) $display("FAIL byte_signed got %h want ffffffa5", o_rsp_rdata); else passed++;
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
      total++; if (o_rsp_rdata !== 32'h000000A5) $display("FAIL byte_unsigned got %h want 000000a5", o_rsp_rdata); else passed++;
   endtask

   task automatic test_half();
      drive(1, 1, 2'd2, 0, 16'h0010, 32'h80011234, 1); ref_store(2'd2, 16'h0010, 32'h80011234);
      drive(1, 0, 2'd1, 0, 16'h0012, 32'h0, 1);
      drive(1, 0, 2'd1, 0, 16'h0010, 32'h0, 1);
      total++; if (o_rsp_rdata !== 32'hFFFF8001) $display("FAIL half_hi got %h want ffff8001", o_rsp_rdata); else passed++;
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
      total++; if (o_rsp_rdata !== 32'h00001234) $display("FAIL half_lo got %h want 00001234", o_rsp_rdata); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] ba [4];
      logic [1:0]  bs [4];
      logic        bu [4];
      logic [31:0] be [4];
      ba = '{16'h0010, 16'h0012, 16'h0013, 16'h0010};
      bs = '{2'd2, 2'd1, 2'd0, 2'd0};
      bu = '{1'b0, 1'b0, 1'b0, 1'b1};
      be = '{32'h80011234, 32'hFFFF8001, 32'hFFFFFF80, 32'h00000034};
      drive(1, 0, 2'd2, 0, 16'h0010, 32'h0, 1);
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 2'd2, 0, 16'h0020, 32'h0, 0);
         total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h80011234 || o_req_ready !== 1'b0 || o_mem_en !== 1'b0)
            $display("FAIL stall_%0d got v=%b d=%h rdy=%b en=%b want 1/80011234/0/0", k, o_rsp_valid, o_rsp_rdata, o_req_ready, o_mem_en);
         else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, bs[k], bu[k], ba[k], 32'h0, 1);
         total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== (k == 0 ? 32'h80011234 : be[k-1]) || o_mem_en !== 1'b1)
            $display("FAIL b2b_%0d got v=%b d=%h en=%b want 1/%h/1", k, o_rsp_valid, o_rsp_rdata, o_mem_en, (k == 0 ? 32'h80011234 : be[k-1]));
         else passed++;
      end
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
      total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== be[3])
         $display("FAIL b2b_last got v=%b d=%h want 1/%h", o_rsp_valid, o_rsp_rdata, be[3]); else passed++;
   endtask

   task automatic test_misalign();
      logic        e_err;
      logic [31:0] e_data;
      e_err  = ref_err(2'd2, 16'h0012);
      e_data = e_err ? 32'h0 : ref_load(2'd2, 0, 16'h0012);
      drive(1, 0, 2'd2, 0, 16'h0012, 32'h0, 1);
      total++; if (o_mem_en !== !e_err) $display("FAIL misalign_en got %b want %b", o_mem_en, !e_err); else passed++;
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
      total++; if (o_rsp_err !== e_err || o_rsp_rdata !== e_data)
         $display("FAIL misalign_rsp got err=%b d=%h want err=%b d=%h", o_rsp_err, o_rsp_rdata, e_err, e_data); else passed++;
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 2'd2, 0, 16'h0010, 32'h0, 1);
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0014; req_wdata = 32'hFFFFFFFF;
      #3;
      total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
         $display("FAIL midrst_rsp got v=%b d=%h want 0/0", rsp_valid, rsp_rdata); else passed++;
      total++; if ({mem_en, mem_we, mem_addr, mem_din} !== '0)
         $display("FAIL midrst_mem got en=%b we=%b addr=%h din=%h want all 0", mem_en, mem_we, mem_addr, mem_din); else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = 1'b0;
      #3;
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL midrst_release got rdy=%b v=%b want 1/0", req_ready, rsp_valid); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic        pend = 1'b0, e_err = 1'b0, v, we, uns, rr, e_rdy, hs, acc, h_err;
      logic [31:0] e_data = 32'h0, wd;
      logic [1:0]  sz;
      logic [15:0] a;
      for (int it = 0; it < 300; it++) begin
         v = 1'($urandom_range(0, 3) != 0); we = 1'($urandom); uns = 1'($urandom);
         rr = 1'($urandom_range(0, 3) != 0); sz = 2'($urandom_range(0, 3));
         a = 16'($urandom_range(0, 63)); wd = $urandom;
         e_rdy = !pend || rr;
         hs = v && e_rdy;
         h_err = ref_err(sz, a);
         acc = hs && !h_err;
         drive(v, we, sz, uns, a, wd, rr);
         total++; if (o_req_ready !== e_rdy || o_rsp_valid !== pend)
            $display("FAIL rnd_hs it=%0d got rdy=%b v=%b want %b/%b", it, o_req_ready, o_rsp_valid, e_rdy, pend); else passed++;
         if (pend) begin
            total++; if (o_rsp_rdata !== e_data || o_rsp_err !== e_err)
               $display("FAIL rnd_rsp it=%0d got d=%h err=%b want %h/%b", it, o_rsp_rdata, o_rsp_err, e_data, e_err); else passed++;
         end
         total++; if (o_mem_en !== acc || o_mem_we !== ((acc && we) ? ref_lanes(sz, a) : 4'b0) ||
                      o_mem_din !== ((acc && we) ? ref_din(sz, wd) : 32'h0) || o_mem_addr !== (acc ? a[15:2] : 14'h0))
            $display("FAIL rnd_mem it=%0d got en=%b we=%b din=%h addr=%h", it, o_mem_en, o_mem_we, o_mem_din, o_mem_addr);
         else passed++;
         if (pend && rr) pend = 1'b0;
         if (hs) begin
            pend   = 1'b1;
            e_err  = h_err;
            e_data = (we || h_err) ? 32'h0 : ref_load(sz, uns, a);
            if (we && !h_err) ref_store(sz, a, wd);
         end
      end
      drive(0, 0, 2'd0, 0, 16'h0, 32'h0, 1);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) pmem[i] = 32'h0;
      for (int i = 0; i < 65536; i++) bmem[i] = 8'h0;
      mem_dout = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
